vend_controller: RTL and testbench
==================================

# vend_controller

Front-end controller for the vending machine: arbitrates two coin slots, accumulates credit, sequences a product-dispense handshake and then pays out change coin-by-coin through a hopper handshake. It sits between the coin acceptors / keypad and the dispenser / change hopper and owns all credit bookkeeping. Credit is counted in units of 5 cents.

## Interface
- PRICE0, default 3: price of item 0 in units.
- PRICE1, default 4: price of item 1 in units.
- PRICE2, default 5: price of item 2 in units; item code 3 is invalid.
- MAX_CREDIT, default 20: credit ceiling in units, must fit 5 bits.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- coin0_valid / coin1_valid  input  1  slot has a coin presented.
- coin0_val / coin1_val  input  2  coin code: 01 = 1 unit, 10 = 2 units, 11 = slug, 00 = treated as slug.
- coin0_ready / coin1_ready  output  1  slot coin accepted this cycle when valid && ready.
- coin_reject  output  1  one-cycle pulse: an accepted coin was a slug.
- sel_valid  input  1  product selection strobe.
- sel_item  input  2  product code.
- cancel  input  1  refund request.
- short_credit  output  1  one-cycle pulse: selection refused (low credit or invalid item).
- vend_req  output  1  dispense request, level.
- vend_item  output  2  item being dispensed, stable while vend_req.
- vend_ack  input  1  dispenser done.
- chg_req  output  1  change coin request, level.
- chg_coin  output  2  coin to eject: 10 = 2 units, 01 = 1 unit.
- chg_ack  input  1  hopper ejected the coin.
- credit  output  5  current credit in units.
- busy  output  1  high in VEND or CHANGE.

## Operation
- States: IDLE, VEND, CHANGE. Moore outputs: vend_req = (state==VEND), chg_req = (state==CHANGE), busy = !IDLE.
- IDLE, coins: a slot is ready only if state==IDLE, sel_valid==0, and credit+2 <= MAX_CREDIT. If both slots are valid, only the round-robin winner gets ready; pointer starts at slot 0 and flips to the other slot after each grant. A single valid slot is granted regardless of the pointer. Accepted 01/10 adds 1/2 units; 11/00 adds 0 and pulses coin_reject.
- IDLE, select (priority over coins and cancel): valid item with credit >= price -> credit -= price, latch vend_item, go VEND. Otherwise stay IDLE, pulse short_credit, credit unchanged.
- IDLE, cancel (no sel_valid): credit > 0 -> CHANGE; credit == 0 -> ignored.
- VEND: hold vend_req/vend_item; ignore coins, sel, cancel. On vend_ack: credit > 0 -> CHANGE, else IDLE.
- CHANGE: chg_coin = 10 if credit >= 2 else 01. On chg_ack: credit -= coin value; if the result is 0 -> IDLE, else stay (next coin recomputed).
- Credit never exceeds MAX_CREDIT and never underflows.
- Reset (asynchronous, rst low): state IDLE, credit 0, rr pointer slot 0, vend_item 0, all outputs 0. Mid-VEND/CHANGE reset drops vend_req/chg_req immediately; the credit is forfeited.

## Timing
- Coin handshake completes on the edge where valid && ready; credit updates on that edge. coin_reject is high the cycle after.
- sel accepted at edge N: vend_req high from N+1; short_credit pulse is high N+1 only.
- vend_ack sampled at edge M: vend_req low from M+1; chg_req high from M+1 if change is due.
- chg_ack at edge K: credit and chg_coin updated at K+1; chg_req continuous across consecutive coins.
- Acks arriving outside their state are ignored. Back-to-back selections are spaced by at least vend duration + 1 cycle.

## Test plan
- Reset: hold rst low with random inputs -> all outputs 0, credit 0; release, coin0 01 -> credit 1.
- Arbitration: both slots valid with 10 for 4 cycles -> grants 0,1,0,1, credit 8; slug on coin1 -> coin_reject pulse, credit unchanged.
- Saturation: credit 19, coin 10 presented -> ready stays low, credit 19.
- Vend + change: credit 10, sel item 0 -> vend_req, vend_item 0, credit 7; vend_ack -> chg_coin 10,10,10,01 on four acks, credit 0, IDLE.
- Refusal: credit 2, sel item 2 -> short_credit one cycle, still IDLE; sel item 3 -> short_credit; cancel -> change 10 once, IDLE.
- Reset mid-CHANGE after one ack -> chg_req drops asynchronously, credit 0, IDLE.

Source files
------------

// File: rtl/vend_controller_if.sv
// Coin, selection, dispense and change-hopper signals of the vending front end.
// The slave modport is the controller; the master modport is the machine around it.
interface vend_controller_if;
  logic       coin0_valid;
  logic [1:0] coin0_val;
  logic       coin0_ready;
  logic       coin1_valid;
  logic [1:0] coin1_val;
  logic       coin1_ready;
  logic       coin_reject;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       cancel;
  logic       short_credit;
  logic       vend_req;
  logic [1:0] vend_item;
  logic       vend_ack;
  logic       chg_req;
  logic [1:0] chg_coin;
  logic       chg_ack;
  logic [4:0] credit;
  logic       busy;

  modport slave (
    input  coin0_valid, coin0_val, coin1_valid, coin1_val,
    input  sel_valid, sel_item, cancel, vend_ack, chg_ack,
    output coin0_ready, coin1_ready, coin_reject, short_credit,
    output vend_req, vend_item, chg_req, chg_coin, credit, busy
  );

  modport master (
    output coin0_valid, coin0_val, coin1_valid, coin1_val,
    output sel_valid, sel_item, cancel, vend_ack, chg_ack,
    input  coin0_ready, coin1_ready, coin_reject, short_credit,
    input  vend_req, vend_item, chg_req, chg_coin, credit, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Vending front end: two-slot coin arbitration, credit bookkeeping, dispense
// handshake and coin-by-coin change payout. Credit is in 5-cent units.
//
// state  | meaning
// IDLE   | accepting coins, selections and cancel
// VEND   | dispense requested, waiting for vend_ack
// CHANGE | paying out credit one coin per chg_ack
module vend_controller #(
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int PRICE2     = 5,
  parameter int MAX_CREDIT = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  vend_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

  state_t     state, state_nxt;
  logic [4:0] credit, credit_nxt;
  logic [1:0] item, item_nxt;
  logic       rr, rr_nxt;
  logic       reject, reject_nxt;
  logic       short, short_nxt;

  logic       room, can_coin, ready0, ready1, grant0, grant1;
  logic [1:0] coin_code;
  logic [4:0] coin_units, price, chg_units;
  logic       item_ok;

  always_comb begin
    room     = ({1'b0, credit} + 6'd2) <= 6'(MAX_CREDIT);
    // Gating with rst_n keeps the ready outputs low while reset is held.
    can_coin = rst_n && (state == IDLE) && !bus.sel_valid && room;
    ready0   = can_coin && (!bus.coin1_valid || !rr);
    ready1   = can_coin && (!bus.coin0_valid || rr);
    grant0   = ready0 && bus.coin0_valid;
    grant1   = ready1 && bus.coin1_valid;
    coin_code = grant1 ? bus.coin1_val : bus.coin0_val;
    case (coin_code)
      2'b01:   coin_units = 5'd1;
      2'b10:   coin_units = 5'd2;
      default: coin_units = 5'd0;
    endcase
    item_ok = (bus.sel_item != 2'd3);
    case (bus.sel_item)
      2'd0:    price = 5'(PRICE0);
      2'd1:    price = 5'(PRICE1);
      2'd2:    price = 5'(PRICE2);
      default: price = 5'd0;
    endcase
    chg_units = (credit >= 5'd2) ? 5'd2 : 5'd1;
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    item_nxt   = item;
    rr_nxt     = rr;
    reject_nxt = 1'b0;
    short_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sel_valid) begin
          if (item_ok && (credit >= price)) begin
            credit_nxt = credit - price;
            item_nxt   = bus.sel_item;
            state_nxt  = VEND;
          end else begin
            short_nxt = 1'b1;
          end
        end else begin
          if (grant0 || grant1) begin
            credit_nxt = credit + coin_units;
            reject_nxt = (coin_units == 5'd0);
            rr_nxt     = !grant1;
          end
          if (bus.cancel && (credit != 5'd0)) state_nxt = CHANGE;
        end
      end
      VEND: begin
        if (bus.vend_ack) state_nxt = (credit != 5'd0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        if (bus.chg_ack) begin
          credit_nxt = credit - chg_units;
          if (credit == chg_units) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      credit <= '0;
      item   <= '0;
      rr     <= 1'b0;
      reject <= 1'b0;
      short  <= 1'b0;
    end else begin
      state  <= state_nxt;
      credit <= credit_nxt;
      item   <= item_nxt;
      rr     <= rr_nxt;
      reject <= reject_nxt;
      short  <= short_nxt;
    end
  end

  assign bus.coin0_ready  = ready0;
  assign bus.coin1_ready  = ready1;
  assign bus.coin_reject  = reject;
  assign bus.short_credit = short;
  assign bus.vend_req     = (state == VEND);
  assign bus.vend_item    = item;
  assign bus.chg_req      = (state == CHANGE);
  assign bus.chg_coin     = (state != CHANGE) ? 2'b00 : ((credit >= 5'd2) ? 2'b10 : 2'b01);
  assign bus.credit       = credit;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_vend_controller;

  localparam int K_GRANT = 0;
  localparam int K_REJ   = 1;
  localparam int K_SHORT = 2;
  localparam int K_VEND  = 3;
  localparam int K_CHG   = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vend_controller_if bus ();

  vend_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  logic prev_vend = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic see(input int k, input int v);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d val=%0d at %0t", k, v, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.val != v) begin
        failures++;
        $display("FAIL event actual kind=%0d val=%0d expected kind=%0d val=%0d at %0t",
                 k, v, e.kind, e.val, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vend = 1'b0;
    end else begin
      if (bus.coin_reject) see(K_REJ, 0);
      if (bus.short_credit) see(K_SHORT, 0);
      if (bus.vend_req && !prev_vend) see(K_VEND, int'(bus.vend_item));
      if (bus.chg_req && bus.chg_ack) see(K_CHG, int'(bus.chg_coin));
      if (bus.coin0_valid && bus.coin0_ready) see(K_GRANT, 0);
      if (bus.coin1_valid && bus.coin1_ready) see(K_GRANT, 1);
      prev_vend = bus.vend_req;
    end
  end

  task automatic clear_inputs();
    bus.coin0_valid = 1'b0;
    bus.coin0_val   = 2'b00;
    bus.coin1_valid = 1'b0;
    bus.coin1_val   = 2'b00;
    bus.sel_valid   = 1'b0;
    bus.sel_item    = 2'd0;
    bus.cancel      = 1'b0;
    bus.vend_ack    = 1'b0;
    bus.chg_ack     = 1'b0;
  endtask

  task automatic do_reset();
    chk("pending_events", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      bus.coin0_valid = 1'($urandom);
      bus.coin0_val   = 2'($urandom);
      bus.coin1_valid = 1'($urandom);
      bus.coin1_val   = 2'($urandom);
      bus.sel_valid   = 1'($urandom);
      bus.sel_item    = 2'($urandom);
      bus.cancel      = 1'($urandom);
      bus.vend_ack    = 1'($urandom);
      bus.chg_ack     = 1'($urandom);
      #1;
      chk("reset_outputs", int'({bus.coin0_ready, bus.coin1_ready, bus.coin_reject,
                                 bus.short_credit, bus.vend_req, bus.vend_item,
                                 bus.chg_req, bus.chg_coin, bus.busy}), 0);
      chk("reset_credit", int'(bus.credit), 0);
    end
    clear_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic coin(input int s, input logic [1:0] v);
    int n;
    push(K_GRANT, s);
    if (v == 2'b11 || v == 2'b00) push(K_REJ, 0);
    if (s == 0) begin
      bus.coin0_valid = 1'b1;
      bus.coin0_val   = v;
    end else begin
      bus.coin1_valid = 1'b1;
      bus.coin1_val   = v;
    end
    #1;
    n = 0;
    while (!(s == 0 ? bus.coin0_ready : bus.coin1_ready) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL coin_ready_timeout slot=%0d waited=%0d cycles", s, n);
    end
    @(posedge clk);
    #1;
    bus.coin0_valid = 1'b0;
    bus.coin1_valid = 1'b0;
  endtask

  task automatic pulse_sel(input logic [1:0] it);
    bus.sel_valid = 1'b1;
    bus.sel_item  = it;
    @(posedge clk);
    #1;
    bus.sel_valid = 1'b0;
  endtask

  task automatic pulse_cancel();
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
  endtask

  initial begin
    clear_inputs();

    // Reset, then first coin
    do_reset();
    coin(0, 2'b01);
    chk("first_coin_credit", int'(bus.credit), 1);

    // Round-robin arbitration from a fresh pointer
    do_reset();
    push(K_GRANT, 0);
    push(K_GRANT, 1);
    push(K_GRANT, 0);
    push(K_GRANT, 1);
    bus.coin0_valid = 1'b1;
    bus.coin0_val   = 2'b10;
    bus.coin1_valid = 1'b1;
    bus.coin1_val   = 2'b10;
    repeat (4) @(posedge clk);
    #1;
    bus.coin0_valid = 1'b0;
    bus.coin1_valid = 1'b0;
    chk("arb_credit", int'(bus.credit), 8);

    coin(1, 2'b11);
    chk("slug_reject_pulse", int'(bus.coin_reject), 1);
    chk("slug_credit", int'(bus.credit), 8);
    @(posedge clk);
    #1;
    chk("slug_reject_clear", int'(bus.coin_reject), 0);

    // Saturation at 19
    repeat (5) coin(0, 2'b10);
    coin(0, 2'b01);
    chk("sat_credit_19", int'(bus.credit), 19);
    bus.coin0_valid = 1'b1;
    bus.coin0_val   = 2'b10;
    repeat (3) begin
      #1;
      chk("sat_ready_low", int'(bus.coin0_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.coin0_valid = 1'b0;
    chk("sat_credit_hold", int'(bus.credit), 19);

    // Vend item 0 from 10, change 2,2,2,1
    do_reset();
    repeat (5) coin(0, 2'b10);
    chk("vend_start_credit", int'(bus.credit), 10);
    push(K_VEND, 0);
    pulse_sel(2'd0);
    chk("vend_req_high", int'(bus.vend_req), 1);
    chk("vend_item", int'(bus.vend_item), 0);
    chk("vend_credit", int'(bus.credit), 7);
    chk("vend_busy", int'(bus.busy), 1);
    push(K_CHG, 2);
    push(K_CHG, 2);
    push(K_CHG, 2);
    push(K_CHG, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("vend_hold", int'(bus.vend_req), 1);
    bus.vend_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.vend_ack = 1'b0;
    chk("vend_req_drop", int'(bus.vend_req), 0);
    chk("chg_req_high", int'(bus.chg_req), 1);
    bus.chg_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.chg_ack = 1'b0;
    chk("chg_done_credit", int'(bus.credit), 0);
    chk("chg_done_idle", int'(bus.busy), 0);
    chk("chg_req_low", int'(bus.chg_req), 0);

    // Refusals and cancel
    do_reset();
    coin(0, 2'b10);
    push(K_SHORT, 0);
    pulse_sel(2'd2);
    chk("short_low_credit", int'(bus.short_credit), 1);
    chk("short_idle", int'(bus.busy), 0);
    chk("short_credit_kept", int'(bus.credit), 2);
    @(posedge clk);
    #1;
    chk("short_one_cycle", int'(bus.short_credit), 0);
    push(K_SHORT, 0);
    pulse_sel(2'd3);
    chk("short_bad_item", int'(bus.short_credit), 1);
    push(K_CHG, 2);
    pulse_cancel();
    chk("cancel_chg_req", int'(bus.chg_req), 1);
    chk("cancel_chg_coin", int'(bus.chg_coin), 2);
    bus.chg_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.chg_ack = 1'b0;
    chk("cancel_idle", int'(bus.busy), 0);
    chk("cancel_credit", int'(bus.credit), 0);

    // Reset in the middle of a change payout
    do_reset();
    repeat (5) coin(0, 2'b10);
    push(K_CHG, 2);
    pulse_cancel();
    bus.chg_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.chg_ack = 1'b0;
    chk("mid_chg_credit", int'(bus.credit), 8);
    chk("mid_chg_req", int'(bus.chg_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_chg_drop", int'(bus.chg_req), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_credit", int'(bus.credit), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (5) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
